fivebit_8lane_packer: RTL and testbench
=======================================

# fivebit_8lane_packer

Serial-to-parallel front end for the 8-way 5-bit ternary adder tree. It accepts a stream of 5-bit samples, one per cycle under a valid/ready handshake, and converts each to offset binary when configured. It packs eight samples into a 40-bit lane word and presents it with a valid/ready handshake, so the adder always sees unsigned offset-binary operands. A double-buffer (assembly register plus output register) sustains one sample per clock with no combinational path from `m_ready_i` to `s_ready_o`.

## Interface
- `SIGNED_IN`, default 1: 1 = input is two's complement and is converted to offset binary by inverting bit 4; 0 = input passes through unchanged.
- `PAD_VALUE`, default 5'h10: value written into unfilled lanes of a short frame (offset-binary zero).
- `clk_i`  in  1: single clock; all logic is rising-edge.
- `rst_i`  in  1: synchronous, active-high reset.
- `s_data_i`  in  5: input sample.
- `s_valid_i`  in  1: input sample valid.
- `s_last_i`  in  1: current sample closes the frame early; qualified by `s_valid_i & s_ready_o`.
- `s_ready_o`  out  1: packer can accept a sample this cycle.
- `m_lane_o`  out  40: packed frame; lane k = bits [5k+4:5k]; lane 0 = first sample accepted.
- `m_count_o`  out  4: number of real samples in the frame, 1..8.
- `m_valid_o`  out  1: frame valid.
- `m_ready_i`  in  1: downstream accepts the frame.

## Operation
- Input transfer occurs when `s_valid_i & s_ready_o`. Output transfer occurs when `m_valid_o & m_ready_i`.
- The converted sample is `SIGNED_IN ? {~s_data_i[4], s_data_i[3:0]} : s_data_i`.
- Assembly FSM, with 3-bit write index `idx`:
  - FILL: each input transfer writes the converted sample into lane `idx`, and `idx` increments.
  - The frame closes on the transfer where `idx==7` or `s_last_i==1`.
  - On close, lanes `idx+1..7` are written with `PAD_VALUE`, and count = `idx+1`.
  - On close, if the output register is free this edge (`!m_valid_o | m_ready_i`), the frame, including the closing sample, loads directly into `m_lane_o`/`m_count_o`, `m_valid_o` is set, `idx` returns to 0, and the FSM stays in FILL.
  - Otherwise the closed frame stays in assembly and the FSM enters HOLD.
  - HOLD: `s_ready_o=0`. On the first output transfer, the held frame moves into the output register the same edge, `m_valid_o` stays 1, `idx` returns to 0, and the FSM returns to FILL.
- `s_ready_o = (state==FILL) & !rst_i`.
- `s_last_i` on the 8th sample is a normal full frame with count 8.
- While `m_valid_o==1 & m_ready_i==0`, `m_lane_o` and `m_count_o` are held stable.
- FILL continues accepting samples of the next frame while an earlier frame waits at the output.
- A full-frame `m_count_o` is 4'd8; values 0 and 9..15 never occur.

## Timing
- Reset values:
  - `m_valid_o=0`, `m_lane_o=0`, `m_count_o=0`.
  - `s_ready_o=0` while `rst_i` is high; `s_ready_o=1` in the first cycle after reset.
  - FSM = FILL, `idx=0`.
- Reset asserted mid-frame discards the partial assembly frame and any held or output frame. No frame is emitted for them.
- Latency: if the closing sample is accepted at edge N, `m_valid_o` is 1 from the cycle after edge N.
- Throughput: with `m_ready_i` held high, one frame every 8 cycles with `s_ready_o` continuously 1.
- Backpressure: a stalled output absorbs one complete further frame (in HOLD). `s_ready_o` drops in the cycle after that frame closes and rises in the cycle after the output transfer.
- Simultaneous events:
  - A closing input and an output transfer on the same edge load the new frame into the output register. No bubble, no HOLD.
  - In HOLD, an output transfer and the assembly move on the same edge keep `m_valid_o=1` continuously.

## Test plan
- SIGNED_IN=1, samples 5'h10, 5'h00, 5'h0F, 5'h1F, 5'h01, 5'h11, 5'h08, 5'h18 (the 8th closes the frame), `m_ready_i=1` -> one frame, lanes 0..7 = 00,10,1F,0F,11,01,18,08, count 8, `m_valid_o` high the cycle after the 8th accept.
- SIGNED_IN=1, single sample 5'h03 with `s_last_i=1` -> lane 0 = 5'h13, lanes 1..7 = 5'h10, count 1.
- Continuous 24 samples (values 0..23 mod 32, SIGNED_IN=0), `m_ready_i=1` -> three frames 8 cycles apart, `s_ready_o` never low, lane k of frame f = 8f+k.
- `m_ready_i=0` while 16 samples arrive -> frame 1 held stable at the output, frame 2 held in assembly, `s_ready_o` low after the 16th accept. Raise `m_ready_i` -> frame 1, then frame 2 the next cycle, `m_valid_o` continuously 1, `s_ready_o` high the cycle after frame 1 transfers.
- Assert `rst_i` for one cycle after 5 samples of a frame, then send 8 fresh samples -> only the fresh frame appears, count 8, no residue from the discarded samples.
- Random valid/ready stalls (50%) with random `s_last_i` over 10k samples -> scoreboard matches every lane and count, and no sample is lost or duplicated.

Source files
------------

// File: rtl/fivebit_8lane_packer_if.sv
// Sample-in / frame-out handshake bundle for the 5-bit 8-lane packer.
// The packer takes the slave view; whoever feeds samples and drains frames takes master.
interface fivebit_8lane_packer_if;
  logic [4:0]  s_data_i;
  logic        s_valid_i;
  logic        s_last_i;
  logic        s_ready_o;
  logic [39:0] m_lane_o;
  logic [3:0]  m_count_o;
  logic        m_valid_o;
  logic        m_ready_i;

  modport slave (
    input  s_data_i, s_valid_i, s_last_i, m_ready_i,
    output s_ready_o, m_lane_o, m_count_o, m_valid_o
  );

  modport master (
    output s_data_i, s_valid_i, s_last_i, m_ready_i,
    input  s_ready_o, m_lane_o, m_count_o, m_valid_o
  );
endinterface

// File: rtl/fivebit_8lane_packer.sv
// Packs up to eight 5-bit samples into a 40-bit offset-binary lane word,
// double-buffered (assembly + output register) for one sample per clock.
//
// state | meaning
// FILL  | accepting samples into the assembly register
// HOLD  | closed frame parked in assembly, waiting for the output register
module fivebit_8lane_packer #(
  parameter bit         SIGNED_IN = 1'b1,
  parameter logic [4:0] PAD_VALUE = 5'h10
) (
  input logic                   clk_i,
  input logic                   rst_i,
  fivebit_8lane_packer_if.slave bus
);
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [39:0] asm_lane_q, asm_lane_d;
  logic [3:0]  asm_count_q, asm_count_d;
  logic [39:0] out_lane_q, out_lane_d;
  logic [3:0]  out_count_q, out_count_d;
  logic        out_valid_q, out_valid_d;

  logic        s_ready;
  logic        in_xfer;
  logic        out_xfer;
  logic        out_free;
  logic        closing;
  logic [4:0]  sample;
  logic [39:0] closed_lane;
  logic [3:0]  closed_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (closing && !out_free) state_d = HOLD;
      HOLD:    if (out_xfer) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    s_ready = (state_q == FILL) && !rst_i;
  end

  assign in_xfer      = bus.s_valid_i && s_ready;
  assign out_xfer     = out_valid_q && bus.m_ready_i;
  assign out_free     = !out_valid_q || bus.m_ready_i;
  assign closing      = in_xfer && ((idx_q == 3'd7) || bus.s_last_i);
  assign sample       = SIGNED_IN ? {~bus.s_data_i[4], bus.s_data_i[3:0]} : bus.s_data_i;
  assign closed_count = {1'b0, idx_q} + 4'd1;

  // Lanes above idx are padded on every write; they are overwritten before a full close.
  always_comb begin
    closed_lane = asm_lane_q;
    for (int k = 0; k < 8; k++) begin
      if (3'(k) == idx_q) begin
        closed_lane[5*k +: 5] = sample;
      end else if (3'(k) > idx_q) begin
        closed_lane[5*k +: 5] = PAD_VALUE;
      end
    end
  end

  always_comb begin
    idx_d       = idx_q;
    asm_lane_d  = asm_lane_q;
    asm_count_d = asm_count_q;
    out_lane_d  = out_lane_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    if (out_xfer) out_valid_d = 1'b0;
    if (state_q == HOLD) begin
      if (out_xfer) begin
        out_lane_d  = asm_lane_q;
        out_count_d = asm_count_q;
        out_valid_d = 1'b1;
        idx_d       = 3'd0;
      end
    end else if (in_xfer) begin
      if (closing && out_free) begin
        out_lane_d  = closed_lane;
        out_count_d = closed_count;
        out_valid_d = 1'b1;
        idx_d       = 3'd0;
      end else begin
        asm_lane_d  = closed_lane;
        asm_count_d = closed_count;
        idx_d       = closing ? idx_q : idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q       <= 3'd0;
      asm_lane_q  <= 40'd0;
      asm_count_q <= 4'd0;
      out_lane_q  <= 40'd0;
      out_count_q <= 4'd0;
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      asm_lane_q  <= asm_lane_d;
      asm_count_q <= asm_count_d;
      out_lane_q  <= out_lane_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.s_ready_o = s_ready;
  assign bus.m_lane_o  = out_lane_q;
  assign bus.m_count_o = out_count_q;
  assign bus.m_valid_o = out_valid_q;
endmodule

// File: tb/tb_fivebit_8lane_packer.sv
// Directed and random checks of the packer, one signed and one unsigned instance
// driven with identical stimulus; a negedge scoreboard tracks every frame.
module tb_fivebit_8lane_packer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] s_data = 5'd0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fivebit_8lane_packer_if ifs ();
  fivebit_8lane_packer_if ifu ();

  assign ifs.s_data_i  = s_data;
  assign ifs.s_valid_i = s_valid;
  assign ifs.s_last_i  = s_last;
  assign ifs.m_ready_i = m_ready;
  assign ifu.s_data_i  = s_data;
  assign ifu.s_valid_i = s_valid;
  assign ifu.s_last_i  = s_last;
  assign ifu.m_ready_i = m_ready;

  fivebit_8lane_packer #(.SIGNED_IN(1'b1), .PAD_VALUE(5'h10)) u_dut_s (
    .clk_i(clk), .rst_i(rst), .bus(ifs)
  );
  fivebit_8lane_packer #(.SIGNED_IN(1'b0), .PAD_VALUE(5'h10)) u_dut_u (
    .clk_i(clk), .rst_i(rst), .bus(ifu)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: frames stored as raw samples {count, lanes}; signed view derived at compare.
  logic [39:0] sb_cur = 40'd0;
  int          sb_idx = 0;
  logic [43:0] sb_q[$];
  int          sb_samples_in = 0;
  int          sb_samples_out = 0;

  initial begin
    logic [43:0] f;
    logic [39:0] exp_u, exp_s;
    logic [3:0]  cnt;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        sb_idx = 0;
      end else begin
        if (ifs.m_valid_o && m_ready) begin
          check("sb_frame_pending", 64'(sb_q.size() != 0), 64'd1);
          if (sb_q.size() != 0) begin
            f = sb_q.pop_front();
            exp_u = f[39:0];
            cnt = f[43:40];
            exp_s = exp_u;
            for (int k = 0; k < 8; k++)
              if (k < int'(cnt)) exp_s[5*k+4] = ~exp_s[5*k+4];
            check("sb_lane_s", 64'(ifs.m_lane_o), 64'(exp_s));
            check("sb_count_s", 64'(ifs.m_count_o), 64'(cnt));
            check("sb_valid_u", 64'(ifu.m_valid_o), 64'd1);
            check("sb_lane_u", 64'(ifu.m_lane_o), 64'(exp_u));
            check("sb_count_u", 64'(ifu.m_count_o), 64'(cnt));
            sb_samples_out += int'(cnt);
          end
        end
        if (s_valid && ifs.s_ready_o) begin
          sb_cur[5*sb_idx +: 5] = s_data;
          sb_samples_in++;
          if (sb_idx == 7 || s_last) begin
            for (int k = 0; k < 8; k++)
              if (k > sb_idx) sb_cur[5*k +: 5] = 5'h10;
            sb_q.push_back({4'(sb_idx + 1), sb_cur});
            sb_idx = 0;
          end else begin
            sb_idx++;
          end
        end
      end
    end
  end

  logic [4:0] t1_data [8] = '{5'h10, 5'h00, 5'h0F, 5'h1F, 5'h01, 5'h11, 5'h08, 5'h18};

  initial begin
    logic [39:0] e;
    int n;

    // reset
    tick();
    tick();
    check("rst_ready_s", 64'(ifs.s_ready_o), 64'd0);
    check("rst_ready_u", 64'(ifu.s_ready_o), 64'd0);
    check("rst_valid", 64'(ifs.m_valid_o), 64'd0);
    check("rst_lane", 64'(ifs.m_lane_o), 64'd0);
    check("rst_count", 64'(ifs.m_count_o), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready_s", 64'(ifs.s_ready_o), 64'd1);
    check("post_rst_ready_u", 64'(ifu.s_ready_o), 64'd1);

    // full signed frame
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = t1_data[i];
      s_valid = 1'b1;
      tick();
      if (i == 6) check("t1_no_early_valid", 64'(ifs.m_valid_o), 64'd0);
    end
    s_valid = 1'b0;
    check("t1_valid", 64'(ifs.m_valid_o), 64'd1);
    check("t1_lane_s", 64'(ifs.m_lane_o),
          64'({5'h08, 5'h18, 5'h01, 5'h11, 5'h0F, 5'h1F, 5'h10, 5'h00}));
    check("t1_lane_u", 64'(ifu.m_lane_o),
          64'({5'h18, 5'h08, 5'h11, 5'h01, 5'h1F, 5'h0F, 5'h00, 5'h10}));
    check("t1_count", 64'(ifs.m_count_o), 64'd8);
    tick();
    check("t1_drained", 64'(ifs.m_valid_o), 64'd0);

    // single-sample short frame
    s_data = 5'h03;
    s_last = 1'b1;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last = 1'b0;
    check("t2_valid", 64'(ifs.m_valid_o), 64'd1);
    check("t2_lane_s", 64'(ifs.m_lane_o), 64'({{7{5'h10}}, 5'h13}));
    check("t2_lane_u", 64'(ifu.m_lane_o), 64'({{7{5'h10}}, 5'h03}));
    check("t2_count", 64'(ifs.m_count_o), 64'd1);
    tick();
    check("t2_drained", 64'(ifs.m_valid_o), 64'd0);

    // 24 back-to-back samples, three frames
    for (int i = 0; i < 24; i++) begin
      s_data = 5'(i);
      s_valid = 1'b1;
      check("t3_ready", 64'(ifu.s_ready_o), 64'd1);
      tick();
      if (i % 8 == 7) begin
        for (int k = 0; k < 8; k++) e[5*k +: 5] = 5'(8*(i/8) + k);
        check("t3_valid", 64'(ifu.m_valid_o), 64'd1);
        check("t3_lane_u", 64'(ifu.m_lane_o), 64'(e));
        check("t3_count", 64'(ifu.m_count_o), 64'd8);
      end else if (i % 8 == 0 && i > 0) begin
        check("t3_bubble", 64'(ifu.m_valid_o), 64'd0);
      end
    end
    s_valid = 1'b0;
    tick();

    // backpressure: 16 samples into a stalled output
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_data = 5'(i + 3);
      s_valid = 1'b1;
      tick();
      if (i == 7) check("t4_f1_valid", 64'(ifu.m_valid_o), 64'd1);
    end
    s_valid = 1'b0;
    for (int k = 0; k < 8; k++) e[5*k +: 5] = 5'(k + 3);
    check("t4_hold_ready", 64'(ifu.s_ready_o), 64'd0);
    check("t4_hold_valid", 64'(ifu.m_valid_o), 64'd1);
    check("t4_hold_lane", 64'(ifu.m_lane_o), 64'(e));
    tick();
    tick();
    check("t4_stable_lane", 64'(ifu.m_lane_o), 64'(e));
    check("t4_stable_count", 64'(ifu.m_count_o), 64'd8);
    check("t4_stable_ready", 64'(ifs.s_ready_o), 64'd0);
    m_ready = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) e[5*k +: 5] = 5'(k + 11);
    check("t4_f2_valid", 64'(ifu.m_valid_o), 64'd1);
    check("t4_f2_lane", 64'(ifu.m_lane_o), 64'(e));
    check("t4_f2_count", 64'(ifu.m_count_o), 64'd8);
    check("t4_ready_back", 64'(ifu.s_ready_o), 64'd1);
    tick();
    check("t4_drained", 64'(ifu.m_valid_o), 64'd0);

    // reset mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) begin
      s_data = 5'(26 + i);
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("t5_rst_ready", 64'(ifu.s_ready_o), 64'd0);
    check("t5_rst_valid", 64'(ifu.m_valid_o), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_data = 5'(i + 1);
      s_valid = 1'b1;
      tick();
      if (i == 6) check("t5_no_residue", 64'(ifu.m_valid_o), 64'd0);
    end
    s_valid = 1'b0;
    for (int k = 0; k < 8; k++) e[5*k +: 5] = 5'(k + 1);
    check("t5_valid", 64'(ifu.m_valid_o), 64'd1);
    check("t5_lane", 64'(ifu.m_lane_o), 64'(e));
    check("t5_count", 64'(ifu.m_count_o), 64'd8);
    tick();

    // random stalls and early closes
    sb_samples_in = 0;
    sb_samples_out = 0;
    n = 0;
    while (sb_samples_in < 10000 && n < 80000) begin
      s_valid = ($urandom_range(0, 1) == 1);
      s_data = 5'($urandom_range(0, 31));
      s_last = ($urandom_range(0, 3) == 0);
      m_ready = ($urandom_range(0, 1) == 1);
      tick();
      n++;
    end
    check("rand_budget", 64'(sb_samples_in >= 10000), 64'd1);
    s_valid = 1'b1;
    s_last = 1'b1;
    s_data = 5'h07;
    m_ready = 1'b1;
    n = 0;
    while (!ifs.s_ready_o && n < 50) begin
      tick();
      n++;
    end
    check("flush_ready", 64'(ifs.s_ready_o), 64'd1);
    tick();
    s_valid = 1'b0;
    s_last = 1'b0;
    n = 0;
    while (ifs.m_valid_o && n < 50) begin
      tick();
      n++;
    end
    check("flush_drained", 64'(ifs.m_valid_o), 64'd0);
    check("rand_queue_empty", 64'(sb_q.size()), 64'd0);
    check("rand_conserved", 64'(sb_samples_out), 64'(sb_samples_in));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
